seg7_scanner: RTL and testbench

Multiplexed seven-segment display driver, directly downstream of `clock_div16`. Its `scan_clk` input is the divider's `out_clk`, sampled as data in the `in_clk` domain. Each rising edge of `scan_clk` advances to the next digit. The block drives one anode at a time with the hex-decoded nibble, decimal point and optional leading-zero blanking. A shadow/display register pair keeps every frame tear-free.

---
 rtl/seg7_pkg.sv | 25 ++
 rtl/seg7_decode.sv | 11 +
 rtl/seg7_scanner.sv | 109 ++++++++++
 tb/tb_seg7_scanner.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/seg7_pkg.sv
// Shared constants for the seven-segment scanner: hex segment table,
// polarity helpers for idle anode/segment levels, decoder port widths.
package seg7_pkg;

   localparam int NIBBLE_W   = 4;
   localparam int SEG_W      = 7;
   localparam int MAX_DIGITS = 8;

   // Active-high {g,f,e,d,c,b,a} patterns for hex digits 0..F
   localparam logic [SEG_W-1:0] SEG_TABLE [16] = '{
      7'b0111111, 7'b0000110, 7'b1011011, 7'b1001111,
      7'b1100110, 7'b1101101, 7'b1111101, 7'b0000111,
      7'b1111111, 7'b1101111, 7'b1110111, 7'b1111100,
      7'b0111001, 7'b1011110, 7'b1111001, 7'b1110001
   };

   function automatic logic [SEG_W-1:0] SEG_OFF(input bit active_low);
      return {SEG_W{active_low}};
   endfunction

   function automatic logic [MAX_DIGITS-1:0] AN_OFF(input bit active_low);
      return {MAX_DIGITS{active_low}};
   endfunction

endpackage

// File: rtl/seg7_decode.sv
// Combinational hex nibble to active-high seven-segment pattern.
module seg7_decode
   import seg7_pkg::*;
(
   input  logic [NIBBLE_W-1:0] nibble,
   output logic [SEG_W-1:0]    seg
);

   assign seg = SEG_TABLE[nibble];

endmodule

// File: rtl/seg7_scanner.sv
// Multiplexed seven-segment driver: synchronised scan ticks step a digit
// index; a shadow/display register pair swaps only at frame wrap.
module seg7_scanner
   import seg7_pkg::*;
#(
   parameter int NUM_DIGITS = 4,
   parameter bit ACTIVE_LOW = 1'b1
) (
   input  logic                    in_clk,
   input  logic                    reset,
   input  logic                    scan_clk,
   input  logic [4*NUM_DIGITS-1:0] value,
   input  logic                    load,
   input  logic [NUM_DIGITS-1:0]   dp_mask,
   input  logic                    blank_lz,
   output logic [NUM_DIGITS-1:0]   an,
   output logic [SEG_W-1:0]        seg,
   output logic                    dp
);

   localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
   localparam logic [MAX_DIGITS-1:0] AN_OFF_ALL = AN_OFF(ACTIVE_LOW);
   localparam logic [NUM_DIGITS-1:0] AN_IDLE    = AN_OFF_ALL[NUM_DIGITS-1:0];
   localparam logic [SEG_W-1:0]      SEG_IDLE   = SEG_OFF(ACTIVE_LOW);
   localparam logic [IW-1:0]         IDX_LAST   = IW'(NUM_DIGITS - 1);

   logic s1, s2, s3;
   logic tick, wrap;
   logic [IW-1:0] idx;
   logic active;

   logic [NUM_DIGITS-1:0][NIBBLE_W-1:0] shadow_val, disp_val;
   logic [NUM_DIGITS-1:0] shadow_dp, disp_dp;
   logic shadow_blz, disp_blz;

   assign tick = s2 & ~s3;
   assign wrap = tick && (idx == IDX_LAST);

   always_ff @(posedge in_clk) begin
      if (reset) begin
         s1         <= 1'b0;
         s2         <= 1'b0;
         s3         <= 1'b0;
         idx        <= IDX_LAST;
         active     <= 1'b0;
         shadow_val <= '0;
         shadow_dp  <= '0;
         shadow_blz <= 1'b0;
         disp_val   <= '0;
         disp_dp    <= '0;
         disp_blz   <= 1'b0;
      end else begin
         s1 <= scan_clk;
         s2 <= s1;
         s3 <= s2;
         if (load) begin
            shadow_val <= value;
            shadow_dp  <= dp_mask;
            shadow_blz <= blank_lz;
         end
         // The display takes the pre-load shadow when load and wrap coincide
         if (tick) begin
            active <= 1'b1;
            if (wrap) begin
               idx      <= '0;
               disp_val <= shadow_val;
               disp_dp  <= shadow_dp;
               disp_blz <= shadow_blz;
            end else begin
               idx <= idx + IW'(1);
            end
         end
      end
   end

   // zero_above[i]: nibbles NUM_DIGITS-1 down to i are all zero
   logic [NUM_DIGITS:0] zero_above;
   assign zero_above[NUM_DIGITS] = 1'b1;
   for (genvar i = 0; i < NUM_DIGITS; i++) begin : g_lz
      assign zero_above[i] = zero_above[i+1] & ~|disp_val[i];
   end

   logic [NIBBLE_W-1:0]   nibble;
   logic [SEG_W-1:0]      dec_seg;
   logic                  blank;
   logic [NUM_DIGITS-1:0] onehot;

   assign nibble = disp_val[idx];
   assign blank  = disp_blz && (idx != '0) && zero_above[idx];
   assign onehot = NUM_DIGITS'(1) << idx;

   seg7_decode u_decode (
      .nibble (nibble),
      .seg    (dec_seg)
   );

   always_ff @(posedge in_clk) begin
      if (reset) begin
         an  <= AN_IDLE;
         seg <= SEG_IDLE;
         dp  <= ACTIVE_LOW;
      end else if (active) begin
         an  <= onehot ^ AN_IDLE;
         seg <= (blank ? '0 : dec_seg) ^ SEG_IDLE;
         dp  <= (blank ? 1'b0 : disp_dp[idx]) ^ ACTIVE_LOW;
      end
   end

endmodule

// File: tb/tb_seg7_scanner.sv
// Bench for seg7_scanner: frame-level behavioural model checked every cycle,
// plus literal expectations for the directed scenarios.
module tb_seg7_scanner;

   localparam int N = 4;
   localparam logic [6:0] HEX [16] = '{
      7'b0111111, 7'b0000110, 7'b1011011, 7'b1001111,
      7'b1100110, 7'b1101101, 7'b1111101, 7'b0000111,
      7'b1111111, 7'b1101111, 7'b1110111, 7'b1111100,
      7'b0111001, 7'b1011110, 7'b1111001, 7'b1110001
   };

   logic in_clk = 1'b0;
   logic reset = 1'b1;
   logic scan_clk = 1'b0;
   logic load = 1'b0;
   logic blank_lz = 1'b0;
   logic [4*N-1:0] value = '0;
   logic [N-1:0] dp_mask = '0;
   logic [N-1:0] an;
   logic [6:0] seg;
   logic dp;

   int checks = 0;
   int errors = 0;

   always #10 in_clk = ~in_clk;

   seg7_scanner #(.NUM_DIGITS(N), .ACTIVE_LOW(1'b1)) dut (
      .in_clk   (in_clk),
      .reset    (reset),
      .scan_clk (scan_clk),
      .value    (value),
      .load     (load),
      .dp_mask  (dp_mask),
      .blank_lz (blank_lz),
      .an       (an),
      .seg      (seg),
      .dp       (dp)
   );

   // Behavioural model: rises of scan_clk seen at edge k move the digit at
   // edge k+2 and become visible at edge k+3; frames swap on wrap to 0.
   int edge_n = 0;
   int rises[$];
   bit prev_scan = 1'b0;
   bit started = 1'b0;
   bit model_ok = 1'b0;
   int mdig = N - 1;
   logic [15:0] sh_val = '0, dsp_val = '0;
   logic [N-1:0] sh_dp = '0, dsp_dp = '0;
   bit sh_blz = 1'b0, dsp_blz = 1'b0;
   logic [N-1:0] exp_an;
   logic [6:0] exp_seg;
   logic exp_dp;
   bit blank;
   logic [3:0] nib;

   always @(posedge in_clk) begin
      edge_n++;
      model_ok = 1'b1;
      if (reset) begin
         rises.delete();
         prev_scan = 1'b0;
         started = 1'b0;
         mdig = N - 1;
         sh_val = '0; sh_dp = '0; sh_blz = 1'b0;
         dsp_val = '0; dsp_dp = '0; dsp_blz = 1'b0;
         exp_an = '1; exp_seg = '1; exp_dp = 1'b1;
      end else begin
         if (started) begin
            blank = 1'b0;
            if (dsp_blz && mdig != 0) begin
               blank = 1'b1;
               for (int j = mdig; j < N; j++)
                  if (dsp_val[4*j +: 4] != 4'h0) blank = 1'b0;
            end
            nib = dsp_val[4*mdig +: 4];
            exp_an  = ~(N'(1) << mdig);
            exp_seg = blank ? 7'h7F : ~HEX[nib];
            exp_dp  = blank ? 1'b1 : ~dsp_dp[mdig];
         end else begin
            exp_an = '1; exp_seg = '1; exp_dp = 1'b1;
         end
         if (rises.size() > 0 && rises[0] + 2 == edge_n) begin
            void'(rises.pop_front());
            started = 1'b1;
            mdig = (mdig + 1) % N;
            if (mdig == 0) begin
               dsp_val = sh_val; dsp_dp = sh_dp; dsp_blz = sh_blz;
            end
         end
         if (load) begin
            sh_val = value; sh_dp = dp_mask; sh_blz = blank_lz;
         end
         if (scan_clk && !prev_scan) rises.push_back(edge_n);
         prev_scan = scan_clk;
      end
   end

   always @(negedge in_clk) begin
      if (model_ok) begin
         checks++;
         if ({an, seg, dp} !== {exp_an, exp_seg, exp_dp}) begin
            errors++;
            $display("FAIL model t=%0t an=%b seg=%b dp=%b expected an=%b seg=%b dp=%b",
                     $time, an, seg, dp, exp_an, exp_seg, exp_dp);
         end
      end
   end

   task automatic chk(input string name, input logic [N-1:0] a_exp,
                      input logic [6:0] s_exp, input logic d_exp);
      checks++;
      if ({an, seg, dp} !== {a_exp, s_exp, d_exp}) begin
         errors++;
         $display("FAIL %s an=%b seg=%b dp=%b expected an=%b seg=%b dp=%b",
                  name, an, seg, dp, a_exp, s_exp, d_exp);
      end
   endtask

   task automatic chk_an(input string name, input logic [N-1:0] a_exp);
      checks++;
      if (an !== a_exp) begin
         errors++;
         $display("FAIL %s an=%b expected an=%b", name, an, a_exp);
      end
   endtask

   // One scan pulse; returns once the new digit is on the outputs
   task automatic advance();
      @(negedge in_clk) scan_clk = 1'b1;
      repeat (2) @(negedge in_clk);
      scan_clk = 1'b0;
      repeat (3) @(negedge in_clk);
   endtask

   task automatic do_load(input logic [15:0] v, input logic [N-1:0] m, input logic b);
      @(negedge in_clk);
      load = 1'b1; value = v; dp_mask = m; blank_lz = b;
      @(negedge in_clk);
      load = 1'b0;
   endtask

   task automatic rand_cycle();
      logic [15:0] masks [5];
      masks = '{16'hFFFF, 16'h0FFF, 16'h00FF, 16'h000F, 16'h0000};
      load     = ($urandom_range(0, 5) == 0);
      value    = 16'($urandom) & masks[$urandom_range(0, 4)];
      dp_mask  = N'($urandom);
      blank_lz = 1'($urandom);
      reset    = ($urandom_range(0, 150) == 0);
      @(negedge in_clk);
   endtask

   initial begin
      // Reset held with scan_clk toggling: outputs idle
      for (int i = 0; i < 5; i++) begin
         @(negedge in_clk);
         scan_clk = ~scan_clk;
         chk("reset_off", 4'b1111, 7'b1111111, 1'b1);
      end
      reset = 1'b0;
      scan_clk = 1'b0;
      repeat (3) begin
         @(negedge in_clk);
         chk("pre_tick_off", 4'b1111, 7'b1111111, 1'b1);
      end

      do_load(16'h12AF, 4'b0100, 1'b0);
      advance(); chk("d0_F", 4'b1110, 7'b0001110, 1'b1);
      advance(); chk("d1_A", 4'b1101, 7'b0001000, 1'b1);
      advance(); chk("d2_2", 4'b1011, 7'b0100100, 1'b0);
      advance(); chk("d3_1", 4'b0111, 7'b1111001, 1'b1);

      do_load(16'h0007, 4'b0000, 1'b1);
      advance(); chk("lz7_d0", 4'b1110, 7'b1111000, 1'b1);
      advance(); chk("lz7_d1", 4'b1101, 7'b1111111, 1'b1);
      advance(); chk("lz7_d2", 4'b1011, 7'b1111111, 1'b1);
      advance(); chk("lz7_d3", 4'b0111, 7'b1111111, 1'b1);
      do_load(16'h0000, 4'b0000, 1'b1);
      advance(); chk("lz0_d0", 4'b1110, 7'b1000000, 1'b1);
      advance(); chk("lz0_d1", 4'b1101, 7'b1111111, 1'b1);
      advance(); chk("lz0_d2", 4'b1011, 7'b1111111, 1'b1);
      advance(); chk("lz0_d3", 4'b0111, 7'b1111111, 1'b1);

      // Load lands on the same edge as the wrap: old frame stays up
      @(negedge in_clk) scan_clk = 1'b1;
      repeat (2) @(negedge in_clk);
      scan_clk = 1'b0;
      load = 1'b1; value = 16'h5555; dp_mask = '0; blank_lz = 1'b0;
      @(negedge in_clk);
      load = 1'b0;
      repeat (2) @(negedge in_clk);
      chk("wrapload_old_d0", 4'b1110, 7'b1000000, 1'b1);
      advance(); chk("wrapload_old_d1", 4'b1101, 7'b1111111, 1'b1);
      advance(); chk("wrapload_old_d2", 4'b1011, 7'b1111111, 1'b1);
      advance(); chk("wrapload_old_d3", 4'b0111, 7'b1111111, 1'b1);
      advance(); chk("five_d0", 4'b1110, 7'b0010010, 1'b1);
      advance(); chk("five_d1", 4'b1101, 7'b0010010, 1'b1);
      advance(); chk("five_d2", 4'b1011, 7'b0010010, 1'b1);
      advance(); chk("five_d3", 4'b0111, 7'b0010010, 1'b1);

      // Latency: rise sampled at E0, anode changes at E3
      @(negedge in_clk) scan_clk = 1'b1;
      @(negedge in_clk) chk_an("lat_E0", 4'b0111);
      @(negedge in_clk) chk_an("lat_E1", 4'b0111);
      @(negedge in_clk) chk_an("lat_E2", 4'b0111);
      @(negedge in_clk) chk_an("lat_E3", 4'b1110);
      scan_clk = 1'b0;
      repeat (3) @(negedge in_clk);
      @(negedge in_clk) scan_clk = 1'b1;
      @(negedge in_clk) scan_clk = 1'b0;
      repeat (5) @(negedge in_clk);
      chk_an("one_cycle_pulse", 4'b1101);
      @(negedge in_clk) scan_clk = 1'b1;
      repeat (50) @(negedge in_clk);
      chk_an("held_high", 4'b1011);
      scan_clk = 1'b0;
      repeat (10) @(negedge in_clk);
      chk_an("held_high_after", 4'b1011);

      // One-cycle reset mid-frame
      @(negedge in_clk) reset = 1'b1;
      @(negedge in_clk) reset = 1'b0;
      chk("midreset_off", 4'b1111, 7'b1111111, 1'b1);
      advance(); chk("midreset_d0", 4'b1110, 7'b1000000, 1'b1);

      // Randomised scan timing, loads and occasional resets
      repeat (400) begin
         scan_clk = 1'b1;
         repeat ($urandom_range(1, 4)) rand_cycle();
         scan_clk = 1'b0;
         repeat ($urandom_range(1, 6)) rand_cycle();
      end
      reset = 1'b0;
      load = 1'b0;
      repeat (8) @(negedge in_clk);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
